// File: rtl/mop_issue_stage.sv
// Issue stage: one-entry hold buffer, register scoreboard check, operand read, output register.
// The syscall result is supplied by the environment on syscall_result while syscall_req pulses on the issuing cycle.
package mop_issue_pkg;
    localparam int REG_FILE_SIZE = 16;
    localparam int IDX_W         = $clog2(REG_FILE_SIZE);

    typedef logic [4:0]  reg_id_t;
    typedef logic [63:0] reg_val_t;

    localparam int ID_W  = $bits(reg_id_t);
    localparam int REG_W = $bits(reg_val_t);

    localparam reg_id_t RAX = 5'd0,  RCX = 5'd1,  RDX = 5'd2,  RBX = 5'd3;
    localparam reg_id_t RSP = 5'd4,  RBP = 5'd5,  RSI = 5'd6,  RDI = 5'd7;
    localparam reg_id_t R8  = 5'd8,  R9  = 5'd9,  R10 = 5'd10, R11 = 5'd11;
    localparam reg_id_t R12 = 5'd12, R13 = 5'd13, R14 = 5'd14, R15 = 5'd15;
    localparam reg_id_t RNIL = 5'd16, RV0 = 5'd17, RV8 = 5'd18;
    localparam reg_id_t RIP  = 5'd19, RIMM = 5'd20, RSYSCALL = 5'd21;

    typedef struct packed {
        logic [7:0] opcode;
        reg_id_t    dst_id;
        reg_id_t    src0_id;
        reg_id_t    src1_id;
        reg_val_t   imm;
        reg_val_t   rip_val;
        reg_val_t   src0_val;
        reg_val_t   src1_val;
    } micro_op_t;

    localparam int MOP_W = $bits(micro_op_t);

    typedef enum logic {EMPTY, FULL} slot_state_t;
endpackage

module mop_issue_stage
    import mop_issue_pkg::*;
#(
    parameter int WB_PORTS    = 2,
    parameter int STALL_CNT_W = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [MOP_W-1:0]               in_mop,
    output logic                           in_ready,
    input  logic [REG_FILE_SIZE*REG_W-1:0] reg_file,
    input  logic [WB_PORTS-1:0]            wb_valid,
    input  logic [WB_PORTS*ID_W-1:0]       wb_id,
    input  logic                           flush,
    output logic                           out_valid,
    output logic [MOP_W-1:0]               out_mop,
    input  logic                           out_ready,
    output logic [REG_FILE_SIZE-1:0]       sb_busy,
    output logic [STALL_CNT_W-1:0]         stall_cnt,
    output logic                           syscall_req,
    input  logic [REG_W-1:0]               syscall_result
);

    function automatic logic in_file(reg_id_t id);
        return id < reg_id_t'(REG_FILE_SIZE);
    endfunction

    function automatic logic [REG_FILE_SIZE-1:0] id_mask(reg_id_t id);
        logic [REG_FILE_SIZE-1:0] m;
        m = '0;
        if (in_file(id)) m[id[IDX_W-1:0]] = 1'b1;
        return m;
    endfunction

    // A syscall operand implicitly reads every register, so it waits for a quiet scoreboard.
    function automatic logic reg_ready(reg_id_t id, logic [REG_FILE_SIZE-1:0] busy);
        if (id == RSYSCALL) return busy == '0;
        if (in_file(id))    return !busy[id[IDX_W-1:0]];
        return 1'b1;
    endfunction

    function automatic reg_val_t read_src(reg_id_t id, reg_val_t file_val, reg_val_t imm,
                                          reg_val_t rip, reg_val_t sys);
        if (in_file(id)) return file_val;
        case (id)
            RV8:      return 64'd8;
            RIP:      return rip;
            RIMM:     return imm;
            RSYSCALL: return sys;
            default:  return '0;
        endcase
    endfunction

    slot_state_t              hold_state, hold_state_next;
    slot_state_t              out_state, out_state_next;
    micro_op_t                hold_op, out_op, issue_op;
    logic [REG_FILE_SIZE-1:0] busy_next, wb_clear;
    logic                     hold_full, fire_out, out_free, sb_ok;
    logic                     can_issue, issue, accept;
    reg_val_t                 src0_file, src1_file;

    assign hold_full = (hold_state == FULL);
    assign out_valid = (out_state == FULL);
    assign out_mop   = out_op;
    assign fire_out  = out_valid & out_ready;
    assign out_free  = !out_valid | fire_out;
    assign sb_ok     = reg_ready(hold_op.src0_id, sb_busy) &
                       reg_ready(hold_op.src1_id, sb_busy) &
                       reg_ready(hold_op.dst_id, sb_busy);
    assign can_issue = hold_full & out_free & sb_ok;
    assign in_ready  = !reset & (!hold_full | can_issue);
    assign accept    = in_valid & in_ready & !flush;
    assign issue     = can_issue & !flush;
    assign syscall_req = issue & ((hold_op.src0_id == RSYSCALL) | (hold_op.src1_id == RSYSCALL));

    assign src0_file = reg_file[hold_op.src0_id[IDX_W-1:0]*REG_W +: REG_W];
    assign src1_file = reg_file[hold_op.src1_id[IDX_W-1:0]*REG_W +: REG_W];

    always_comb begin
        issue_op          = hold_op;
        issue_op.src0_val = read_src(hold_op.src0_id, src0_file, hold_op.imm, hold_op.rip_val, syscall_result);
        issue_op.src1_val = read_src(hold_op.src1_id, src1_file, hold_op.imm, hold_op.rip_val, syscall_result);
    end

    always_comb begin
        wb_clear = '0;
        for (int k = 0; k < WB_PORTS; k++) begin
            if (wb_valid[k]) wb_clear |= id_mask(wb_id[k*ID_W +: ID_W]);
        end
    end

    // NOTE: every output of this block is given a default first so no path can infer a latch.
    always_comb begin
        hold_state_next = hold_state;
        out_state_next  = out_state;
        busy_next       = sb_busy & ~wb_clear;
        if (flush) begin
            hold_state_next = EMPTY;
            out_state_next  = EMPTY;
            if (out_valid && !fire_out) busy_next &= ~id_mask(out_op.dst_id);
        end else begin
            if (accept)     hold_state_next = FULL;
            else if (issue) hold_state_next = EMPTY;
            if (issue) begin
                out_state_next = FULL;
                // Applied after the writeback clears so a same-edge set wins.
                busy_next |= id_mask(hold_op.dst_id);
            end else if (fire_out) begin
                out_state_next = EMPTY;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_state <= EMPTY;
            out_state  <= EMPTY;
            sb_busy    <= '0;
            stall_cnt  <= '0;
        end else begin
            hold_state <= hold_state_next;
            out_state  <= out_state_next;
            sb_busy    <= busy_next;
            if (hold_full && out_free && !sb_ok) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_op <= '0;
            out_op  <= '0;
        end else begin
            if (accept) hold_op <= in_mop;
            if (issue)  out_op  <= issue_op;
        end
    end

endmodule

// File: tb/tb_mop_issue_stage.sv
// Self-checking bench for mop_issue_stage: scoreboard queue of expected issued ops plus per-feature tasks.
module tb_mop_issue_stage;
    import mop_issue_pkg::*;

    localparam int WB_PORTS = 2;
    localparam int SCW      = 32;
    localparam reg_val_t SYS_RAX = 64'hC0DE_0000_0000_0042;

    logic                           clk, reset, in_valid, in_ready, flush, out_valid, out_ready, syscall_req;
    logic [MOP_W-1:0]               in_mop, out_mop;
    logic [REG_FILE_SIZE*REG_W-1:0] reg_file;
    logic [WB_PORTS-1:0]            wb_valid;
    logic [WB_PORTS*ID_W-1:0]       wb_id;
    logic [REG_FILE_SIZE-1:0]       sb_busy;
    logic [SCW-1:0]                 stall_cnt;
    logic [REG_W-1:0]               syscall_result;

    reg_val_t  rf_model [REG_FILE_SIZE];
    micro_op_t exp_q [$];
    int        pass_cnt  = 0;
    int        total_cnt = 0;
    int        sys_calls = 0;

    mop_issue_stage #(.WB_PORTS(WB_PORTS), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_mop(in_mop), .in_ready(in_ready),
        .reg_file(reg_file), .wb_valid(wb_valid), .wb_id(wb_id), .flush(flush),
        .out_valid(out_valid), .out_mop(out_mop), .out_ready(out_ready), .sb_busy(sb_busy),
        .stall_cnt(stall_cnt), .syscall_req(syscall_req), .syscall_result(syscall_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic micro_op_t make_op(reg_id_t dst, reg_id_t s0, reg_id_t s1,
                                          reg_val_t imm, reg_val_t rip);
        micro_op_t op;
        op.opcode   = 8'h5A;
        op.dst_id   = dst;
        op.src0_id  = s0;
        op.src1_id  = s1;
        op.imm      = imm;
        op.rip_val  = rip;
        op.src0_val = 64'hBAD0_BAD0_BAD0_BAD0;
        op.src1_val = 64'hBAD1_BAD1_BAD1_BAD1;
        return op;
    endfunction

    function automatic reg_val_t model_src(reg_id_t id, micro_op_t op);
        if (id <= R15) return rf_model[id[3:0]];
        if (id == RV8)      return 64'd8;
        if (id == RIP)      return op.rip_val;
        if (id == RIMM)     return op.imm;
        if (id == RSYSCALL) return SYS_RAX;
        return 64'd0;
    endfunction

    function automatic micro_op_t expected(micro_op_t op);
        micro_op_t e;
        e          = op;
        e.src0_val = model_src(op.src0_id, op);
        e.src1_val = model_src(op.src1_id, op);
        return e;
    endfunction

    // Output monitor: every consumed op is compared against the oldest expectation.
    always @(negedge clk) begin
        micro_op_t e;
        if (syscall_req) sys_calls++;
        if (!reset && out_valid && out_ready) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL out_unexpected: got out_mop=%h, required no output", out_mop);
            end else begin
                e = exp_q.pop_front();
                if (out_mop !== e) $display("FAIL out_mop: got %h, required %h", out_mop, e);
                else pass_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input micro_op_t op, output int waited);
        waited   = 0;
        in_mop   = op;
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(expected(op));
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
            waited++;
            if (waited > 50) begin
                total_cnt++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required acceptance", waited);
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) return;
            tick();
        end
        total_cnt++;
        $display("FAIL drain_timeout: got %0d ops pending, required 0", exp_q.size());
        exp_q.delete();
    endtask

    task automatic writeback(input reg_id_t id0, input logic v0, input reg_id_t id1, input logic v1);
        wb_valid      = {v1, v0};
        wb_id[0 +: ID_W]    = id0;
        wb_id[ID_W +: ID_W] = id1;
        tick();
        wb_valid = '0;
    endtask

    task automatic test_reset();
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b, required 0", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, required 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_mop !== '0) $display("FAIL rst_out_mop: got %h, required 0", out_mop); else pass_cnt++;
        total_cnt++; if (sb_busy !== '0) $display("FAIL rst_sb_busy: got %h, required 0", sb_busy); else pass_cnt++;
        total_cnt++; if (stall_cnt !== '0) $display("FAIL rst_stall_cnt: got %0d, required 0", stall_cnt); else pass_cnt++;
        @(posedge clk); #1 reset = 1'b0;
        tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b, required 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_issue_and_stall();
        int w;
        logic [SCW-1:0] s0;
        out_ready = 1'b1;
        s0 = stall_cnt;
        send_op(make_op(RAX, RBX, RCX, 64'd0, 64'h100), w);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL lat_early: got out_valid=%b, required 0", out_valid); else pass_cnt++;
        send_op(make_op(RNIL, RAX, RIMM, 64'h55, 64'h104), w);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL lat_issue: got out_valid=%b, required 1", out_valid); else pass_cnt++;
        total_cnt++; if (sb_busy !== 16'h0001) $display("FAIL busy_rax: got %h, required 0001", sb_busy); else pass_cnt++;
        repeat (3) tick();
        total_cnt++; if (stall_cnt !== s0 + 3) $display("FAIL stall_count: got %0d, required %0d", stall_cnt, s0 + 3); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b, required 0", in_ready); else pass_cnt++;
        writeback(RAX, 1'b1, RNIL, 1'b0);
        total_cnt++; if (sb_busy !== '0) $display("FAIL wb_clear_rax: got %h, required 0", sb_busy); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL no_bypass: got out_valid=%b, required 0", out_valid); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL stall_release: got out_valid=%b, required 1", out_valid); else pass_cnt++;
        drain();
        total_cnt++; if (stall_cnt !== s0 + 4) $display("FAIL stall_stop: got %0d, required %0d", stall_cnt, s0 + 4); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int w;
        logic [SCW-1:0] s0;
        micro_op_t a;
        out_ready = 1'b0;
        a = make_op(R8, R9, RIMM, 64'h1234, 64'h200);
        send_op(a, w);
        send_op(make_op(R10, R11, RV8, 64'd0, 64'h204), w);
        s0 = stall_cnt;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++;
            if (out_mop !== expected(a)) $display("FAIL bp_stable[%0d]: got %h, required %h", i, out_mop, expected(a));
            else pass_cnt++;
        end
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b, required 0", in_ready); else pass_cnt++;
        total_cnt++; if (stall_cnt !== s0) $display("FAIL bp_no_stall: got %0d, required %0d", stall_cnt, s0); else pass_cnt++;
        out_ready = 1'b1;
        drain();
        writeback(R8, 1'b1, R10, 1'b1);
        total_cnt++; if (sb_busy !== '0) $display("FAIL bp_wb_both: got %h, required 0", sb_busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int w;
        int sum;
        out_ready = 1'b1;
        sum = 0;
        send_op(make_op(R12, RV0, RNIL, 64'd0, 64'h300), w);  sum += w;
        send_op(make_op(R13, RIP, R15, 64'd0, 64'h4000), w);  sum += w;
        send_op(make_op(R14, RAX, RCX, 64'd0, 64'h308), w);   sum += w;
        send_op(make_op(RNIL, RBX, RDX, 64'd0, 64'h30C), w);  sum += w;
        total_cnt++; if (sum !== 0) $display("FAIL b2b_throughput: got %0d wait cycles, required 0", sum); else pass_cnt++;
        drain();
        total_cnt++; if (sb_busy !== 16'h7000) $display("FAIL b2b_busy: got %h, required 7000", sb_busy); else pass_cnt++;
        writeback(R12, 1'b1, R13, 1'b1);
        writeback(R14, 1'b1, RNIL, 1'b1);
        total_cnt++; if (sb_busy !== '0) $display("FAIL b2b_clear: got %h, required 0", sb_busy); else pass_cnt++;
    endtask

    task automatic test_syscall();
        int w;
        int sc0;
        out_ready = 1'b1;
        send_op(make_op(R12, RCX, RDX, 64'd0, 64'h400), w);
        drain();
        sc0 = sys_calls;
        send_op(make_op(RNIL, RSYSCALL, RIP, 64'd0, 64'hDEAD_BEEF), w);
        repeat (4) tick();
        total_cnt++; if (sys_calls !== sc0) $display("FAIL sys_stalled: got %0d calls, required %0d", sys_calls, sc0); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL sys_held: got out_valid=%b, required 0", out_valid); else pass_cnt++;
        writeback(R12, 1'b1, RNIL, 1'b0);
        tick();
        total_cnt++; if (sys_calls !== sc0 + 1) $display("FAIL sys_once: got %0d calls, required %0d", sys_calls, sc0 + 1); else pass_cnt++;
        drain();
        tick();
        total_cnt++; if (sys_calls !== sc0 + 1) $display("FAIL sys_after: got %0d calls, required %0d", sys_calls, sc0 + 1); else pass_cnt++;
    endtask

    task automatic test_flush();
        int w;
        out_ready = 1'b1;
        send_op(make_op(RBP, RAX, RCX, 64'd0, 64'h500), w);
        drain();
        out_ready = 1'b0;
        send_op(make_op(RDX, RAX, RBX, 64'd0, 64'h504), w);
        send_op(make_op(RSI, RV8, RIMM, 64'h77, 64'h508), w);
        total_cnt++; if (sb_busy !== 16'h0024) $display("FAIL fl_pre_busy: got %h, required 0024", sb_busy); else pass_cnt++;
        flush = 1'b1;
        writeback(RBP, 1'b1, RNIL, 1'b0);
        flush = 1'b0;
        exp_q.delete();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL fl_out_valid: got %b, required 0", out_valid); else pass_cnt++;
        total_cnt++; if (sb_busy !== '0) $display("FAIL fl_busy: got %h, required 0", sb_busy); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL fl_hold_empty: got in_ready=%b, required 1", in_ready); else pass_cnt++;
        repeat (2) tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL fl_no_issue: got out_valid=%b, required 0", out_valid); else pass_cnt++;
        out_ready = 1'b1;
    endtask

    task automatic test_set_wins();
        int w;
        out_ready = 1'b1;
        send_op(make_op(RSI, RAX, RCX, 64'd0, 64'h600), w);
        writeback(RNIL, 1'b0, RSI, 1'b1);
        total_cnt++; if (sb_busy !== 16'h0040) $display("FAIL set_wins: got %h, required 0040", sb_busy); else pass_cnt++;
        drain();
        writeback(RBP, 1'b1, RNIL, 1'b1);
        total_cnt++; if (sb_busy !== 16'h0040) $display("FAIL clear_idle: got %h, required 0040", sb_busy); else pass_cnt++;
        writeback(RSI, 1'b1, RNIL, 1'b0);
        total_cnt++; if (sb_busy !== '0) $display("FAIL clear_rsi: got %h, required 0", sb_busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid_stall();
        int w;
        logic [SCW-1:0] s0;
        out_ready = 1'b1;
        s0 = stall_cnt;
        send_op(make_op(RDI, RAX, RAX, 64'd0, 64'h700), w);
        send_op(make_op(RNIL, RDI, RV0, 64'd0, 64'h704), w);
        repeat (3) tick();
        total_cnt++; if (!(stall_cnt > s0)) $display("FAIL rm_stalling: got %0d, required > %0d", stall_cnt, s0); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        total_cnt++; if (sb_busy !== '0) $display("FAIL rm_busy: got %h, required 0", sb_busy); else pass_cnt++;
        total_cnt++; if (stall_cnt !== '0) $display("FAIL rm_stall: got %0d, required 0", stall_cnt); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rm_in_ready: got %b, required 0", in_ready); else pass_cnt++;
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rm_discard: got out_valid=%b, required 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rm_ready: got %b, required 1", in_ready); else pass_cnt++;
    endtask

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_mop         = '0;
        flush          = 1'b0;
        out_ready      = 1'b0;
        wb_valid       = '0;
        wb_id          = '0;
        syscall_result = SYS_RAX;
        for (int i = 0; i < REG_FILE_SIZE; i++) begin
            rf_model[i] = 64'h0101_0101_0000_0000 * reg_val_t'(i + 1) + reg_val_t'(i);
            reg_file[i*REG_W +: REG_W] = rf_model[i];
        end
        test_reset();
        test_issue_and_stall();
        test_backpressure();
        test_back_to_back();
        test_syscall();
        test_flush();
        test_set_wins();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
